// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: load/store type codes,
// FSM state encoding and the legal-code check.
package dmem_pkg;

  localparam logic [4:0] LS_B  = 5'b10000;
  localparam logic [4:0] LS_H  = 5'b01000;
  localparam logic [4:0] LS_W  = 5'b00100;
  localparam logic [4:0] LS_BU = 5'b00010;
  localparam logic [4:0] LS_HU = 5'b00001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  function automatic logic lstype_valid(input logic [4:0] ls);
    return (ls == LS_B) || (ls == LS_H) || (ls == LS_W) ||
           (ls == LS_BU) || (ls == LS_HU);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane decode: store strobes and lane-positioned write data,
// alignment check, and the right-shift/mask that extracts load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [4:0]  lstype,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [3:0]  strb,
  output logic [31:0] wword,
  output logic        misalign,
  output logic [4:0]  rshift,
  output logic [31:0] rmask
);

  logic is_b, is_h, is_w;

  assign is_b = (lstype == LS_B) || (lstype == LS_BU);
  assign is_h = (lstype == LS_H) || (lstype == LS_HU);
  assign is_w = (lstype == LS_W);

  always_comb begin
    strb     = 4'b0000;
    wword    = 32'h0;
    misalign = 1'b0;
    rshift   = 5'd0;
    rmask    = 32'h0;
    if (is_b) begin
      strb   = 4'b0001 << addr_lo;
      wword  = {4{wdata[7:0]}};
      rshift = {addr_lo, 3'b000};
      rmask  = 32'h0000_00ff;
    end else if (is_h) begin
      strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
      wword    = {2{wdata[15:0]}};
      misalign = addr_lo[0];
      rshift   = {addr_lo[1], 4'b0000};
      rmask    = 32'h0000_ffff;
    end else if (is_w) begin
      strb     = 4'b1111;
      wword    = wdata;
      misalign = (addr_lo != 2'b00);
      rmask    = 32'hffff_ffff;
    end
    // Loads never write; replicated data is harmless once strobes are gated.
    if (!we) strb = 4'b0000;
  end

endmodule

// File: rtl/dmem_resp.sv
// Memory-side load/store responder: one request at a time, fixed programmable
// latency from accept to response, byte-lane stores and right-justified loads.
//   state | meaning
//   IDLE  | ready for a request
//   BUSY  | latency countdown; access happens when counter reaches 0
//   RESP  | response held until rsp_ready
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_lstype,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH) << 2;

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        lstype_q, lstype_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              req_ready_q, req_ready_d;

  logic        accept, do_op, wr_en, err;
  logic [3:0]  strb;
  logic [31:0] wword, rd_word, load_data, rmask;
  logic [4:0]  rshift;
  logic        misalign;
  logic [AW-1:0] idx;
  logic [31:0] mem_q [DEPTH];

  dmem_lane_align u_align (
    .lstype   (lstype_q),
    .addr_lo  (addr_q[1:0]),
    .we       (we_q),
    .wdata    (wdata_q),
    .strb     (strb),
    .wword    (wword),
    .misalign (misalign),
    .rshift   (rshift),
    .rmask    (rmask)
  );

  assign accept = req_valid && req_ready_q && (state_q == IDLE);
  assign idx    = addr_q[AW+1:2];
  assign err    = !lstype_valid(lstype_q) ||
                  (we_q && ((lstype_q == LS_BU) || (lstype_q == LS_HU))) ||
                  misalign || ({1'b0, addr_q} >= ADDR_LIMIT);
  assign rd_word   = mem_q[idx];
  assign load_data = (rd_word >> rshift) & rmask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lstype_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lstype_q    <= lstype_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    do_op       = (state_q == BUSY) && (cnt_q == '0);
    wr_en       = do_op && we_q && !err;
    rsp_valid   = (state_q == RESP);
    req_ready_d = (state_d == IDLE);
    we_d        = accept ? req_we     : we_q;
    addr_d      = accept ? req_addr   : addr_q;
    wdata_d     = accept ? req_wdata  : wdata_q;
    lstype_d    = accept ? req_lstype : lstype_q;
    cnt_d       = cnt_q;
    if (accept)                cnt_d = CNT_W'(LATENCY - 1);
    else if (state_q == BUSY && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (do_op) begin
      rsp_err_d   = err;
      rsp_rdata_d = (err || we_q) ? 32'h0 : load_data;
    end
  end

  // Array is deliberately not reset; writes only commit on the access cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) mem_q[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed vector table, handshake/reset
// sequences, and random traffic against a byte-addressed reference model.
module tb_dmem_resp;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam logic [4:0] B = 5'b10000, H = 5'b01000, W = 5'b00100,
                         BU = 5'b00010, HU = 5'b00001;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [4:0]  req_lstype;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] ref_b [DEPTH*4];

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_lstype(req_lstype), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  ls;
    logic [31:0] rd;
    bit          err;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Reference: memory as a flat byte array, access size from the code.
  task automatic model(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] ls, output logic [31:0] rd, output bit e);
    int n;
    case (ls)
      B, BU:   n = 1;
      H, HU:   n = 2;
      W:       n = 4;
      default: n = 0;
    endcase
    e  = (n == 0) || (we && (ls == BU || ls == HU)) || (a >= DEPTH*4);
    if (!e && (a % n) != 0) e = 1;
    rd = 32'h0;
    if (!e) begin
      for (int i = 0; i < n; i++) begin
        if (we) ref_b[a+i] = wd[8*i +: 8];
        else    rd[8*i +: 8] = ref_b[a+i];
      end
    end
  endtask

  task automatic send(input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [4:0] ls);
    int g = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_lstype = ls;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    if (!req_ready) timeout("req_ready");
    @(posedge clk);
    #1;
    req_valid = 0;
    req_we = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
    req_lstype = 5'($urandom);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!rsp_valid && lat < 50);
    if (!rsp_valid) timeout("rsp_valid");
  endtask

  task automatic ack;
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
  endtask

  task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [4:0] ls, output logic [31:0] rd, output bit e,
                     output int lat);
    send(we, a, wd, ls);
    wait_rsp(lat);
    rd = rsp_rdata;
    e  = rsp_err;
    ack();
  endtask

  initial begin
    logic [31:0] rd, exp_rd, v;
    bit e, exp_e, we;
    int lat;
    logic [4:0] ls;
    logic [31:0] a;

    rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    req_lstype = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 0);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst rsp_err",   32'(rsp_err), 0);
    rst_n = 1;

    tbl.push_back('{1, 32'h10, 32'hDEADBEEF, W, 0, 0});
    tbl.push_back('{0, 32'h10, 0, W, 32'hDEADBEEF, 0});
    tbl.push_back('{1, 32'h20, 32'h0, W, 0, 0});
    tbl.push_back('{1, 32'h21, 32'hAA, B, 0, 0});
    tbl.push_back('{1, 32'h23, 32'h55, B, 0, 0});
    tbl.push_back('{0, 32'h20, 0, W, 32'h5500AA00, 0});
    tbl.push_back('{0, 32'h21, 0, B, 32'h000000AA, 0});
    tbl.push_back('{0, 32'h23, 0, BU, 32'h00000055, 0});
    tbl.push_back('{1, 32'h30, 32'h11112222, W, 0, 0});
    tbl.push_back('{1, 32'h32, 32'h8001, H, 0, 0});
    tbl.push_back('{0, 32'h30, 0, W, 32'h80012222, 0});
    tbl.push_back('{0, 32'h32, 0, H, 32'h00008001, 0});
    tbl.push_back('{0, 32'h30, 0, HU, 32'h00002222, 0});
    tbl.push_back('{0, 32'h13, 0, W, 0, 1});
    tbl.push_back('{1, 32'h31, 32'hFFFF, H, 0, 1});
    tbl.push_back('{1, 32'h30, 32'hFF, BU, 0, 1});
    tbl.push_back('{0, 32'h30, 0, 5'b00110, 0, 1});
    tbl.push_back('{0, DEPTH*4, 0, W, 0, 1});
    tbl.push_back('{0, 32'h30, 0, W, 32'h80012222, 0});
    tbl.push_back('{0, 32'h10, 0, W, 32'hDEADBEEF, 0});

    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].ls, exp_rd, exp_e);
      txn(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].ls, rd, e, lat);
      chk($sformatf("tbl%0d rdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d err", i), 32'(e), 32'(tbl[i].err));
      chk($sformatf("tbl%0d latency", i), lat, LAT);
    end

    // Backpressure, plus a second request held during BUSY/RESP.
    model(0, 32'h10, 0, W, exp_rd, exp_e);
    send(0, 32'h10, 0, W);
    req_valid = 1; req_we = 1; req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
    req_lstype = W;
    @(negedge clk);
    chk("busy req_ready", 32'(req_ready), 0);
    wait_rsp(lat);
    v = rsp_rdata;
    for (int k = 0; k < 5; k++) begin
      chk("bp rsp_valid", 32'(rsp_valid), 1);
      chk("bp rsp_rdata", rsp_rdata, exp_rd);
      chk("bp req_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    chk("bp rdata held", rsp_rdata, v);
    ack();
    @(negedge clk);
    chk("ready after ack", 32'(req_ready), 1);
    chk("no rsp after ack", 32'(rsp_valid), 0);
    @(posedge clk);
    #1 req_valid = 0;
    model(1, 32'h10, 32'hCAFEF00D, W, exp_rd, exp_e);
    wait_rsp(lat);
    chk("held store err", 32'(rsp_err), 0);
    chk("held store latency", lat, LAT);
    ack();
    model(0, 32'h10, 0, W, exp_rd, exp_e);
    txn(0, 32'h10, 0, W, rd, e, lat);
    chk("held store readback", rd, exp_rd);

    // rsp_ready high with nothing pending.
    @(negedge clk);
    rsp_ready = 1;
    repeat (4) begin @(negedge clk); chk("idle rsp_valid", 32'(rsp_valid), 0); end
    rsp_ready = 0;

    // Reset during BUSY drops the store.
    model(1, 32'h40, 0, W, exp_rd, exp_e);
    txn(1, 32'h40, 0, W, rd, e, lat);
    send(1, 32'h40, 32'h12345678, W);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst busy req_ready", 32'(req_ready), 0);
    chk("rst busy rsp_valid", 32'(rsp_valid), 0);
    chk("rst busy rsp_rdata", rsp_rdata, 0);
    chk("rst busy rsp_err",   32'(rsp_err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    txn(0, 32'h40, 0, W, rd, e, lat);
    chk("aborted store", rd, 32'h0);

    // Reset during RESP loses the response.
    send(0, 32'h10, 0, W);
    wait_rsp(lat);
    rst_n = 0;
    #1 chk("rst resp rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin @(negedge clk); chk("lost rsp", 32'(rsp_valid), 0); end

    // Random traffic over a 64-byte window, with occasional bad codes/addresses.
    for (int w2 = 0; w2 < 16; w2++) begin
      v = $urandom;
      model(1, 32'h100 + 4*w2, v, W, exp_rd, exp_e);
      txn(1, 32'h100 + 4*w2, v, W, rd, e, lat);
    end
    for (int r = 0; r < 150; r++) begin
      we = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: ls = B; 1: ls = H; 2: ls = W; 3: ls = BU; 4: ls = HU;
        default: ls = 5'($urandom);
      endcase
      a = ($urandom_range(0, 19) == 0) ? 32'($urandom_range(DEPTH*4, DEPTH*8))
                                         : 32'h100 + 32'($urandom_range(0, 63));
      v = $urandom;
      model(we, a, v, ls, exp_rd, exp_e);
      txn(we, a, v, ls, rd, e, lat);
      chk($sformatf("rnd%0d rdata", r), rd, exp_rd);
      chk($sformatf("rnd%0d err", r), 32'(e), 32'(exp_e));
      chk($sformatf("rnd%0d latency", r), lat, LAT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder: the memory-side end of the core's load/store interface.
- Accepts one load/store request at a time over a valid/ready handshake and decodes the 5-bit one-hot LSType into byte-lane strobes.
- Stores write only the addressed lanes. Loads return the addressed byte/halfword right-justified and zero-padded; sign/zero extension stays in the core-side load formatter.
- Models a multi-cycle memory with programmable latency.

Parameters:
- DEPTH, 1024: number of 32-bit words in the array; must be a power of 2.
- ADDR_W, 32: request byte-address width.
- LATENCY, 2: cycles from request acceptance to rsp_valid; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1=store, 0=load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- req_lstype  in  5  10000=b, 01000=h, 00100=w, 00010=bu, 00001=hu.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load data, right-justified, upper bits zero; 0 for stores and errors.
- rsp_err  out  1  request rejected (misaligned / illegal / out of range).

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, latency counter=0. Array contents are not reset.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid&&req_ready; capture we/addr/wdata/lstype.
  - Load counter with LATENCY-1 and go to BUSY.
- BUSY:
  - req_ready=0; decrement counter each cycle.
  - In the cycle the counter is 0: perform the read/write, register rsp_rdata/rsp_err, go to RESP.
  - Result: rsp_valid rises exactly LATENCY cycles after the accept edge.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - req_ready rises the cycle after the handshake; there is no request/response overlap.
- Error checks (any one sets rsp_err=1, rsp_rdata=0, no array write):
  - lstype not one of the five codes.
  - Store with bu/hu code.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr ≥ DEPTH*4.
- Index: word index = addr[log2(DEPTH)+1:2].
- Store strobes:
  - b: lane addr[1:0], written with wdata[7:0].
  - h: lanes {addr[1],0} and {addr[1],1}, written with wdata[15:0].
  - w: all four lanes.
  - Unstrobed lanes are unchanged.
- Load:
  - Shift the word right by 8*addr[1:0] (b/bu) or 16*addr[1] (h/hu).
  - Mask to 8/16 bits; w returns the full word.
  - b and bu return identical data, as do h and hu.
- Boundary conditions:
  - req_valid high outside IDLE is ignored, not queued. The core must hold the request until req_ready.
  - Request inputs changing after acceptance have no effect.
  - rsp_ready held high with no response pending has no effect.
  - Reset mid-BUSY: the transaction is aborted; an uncommitted store is dropped and the array is unchanged.
  - Reset mid-RESP: the response is lost.
  - LATENCY=1: BUSY lasts one cycle.
  - Back-to-back read after write to the same address returns the new data.

Decomposition:
- Package dmem_pkg:
  - LSType constants LS_B, LS_H, LS_W, LS_BU, LS_HU.
  - State enum dmem_state_t {IDLE, BUSY, RESP}.
  - Function lstype_valid().
- Sub-module dmem_lane_align (combinational):
  - Inputs: lstype, addr[1:0], we, wdata.
  - Outputs: 4-bit byte strobe, lane-positioned write word, misalign flag, read shift amount and mask.
  - The top level keeps the FSM, counter, array and response registers.

Test Plan:
- Word store/load: sw 0xDEADBEEF @0x10, then lw @0x10 → rdata=0xDEADBEEF, err=0. rsp_valid exactly LATENCY cycles after each accept.
- Byte lanes: sw 0x00000000 @0x20; sb 0xAA @0x21; sb 0x55 @0x23 → lw @0x20 = 0x5500AA00; lb @0x21 = 0x000000AA; lbu @0x23 = 0x00000055.
- Halfwords: sh 0x8001 @0x32 over word 0x11112222 → lw @0x30 = 0x80012222; lh @0x32 = 0x00008001.
- Errors (each → err=1, rdata=0, prior contents intact on re-read):
  - lw @0x13
  - sh @0x31
  - store with lstype 00010
  - lstype 00110
  - address DEPTH*4
- Handshake/backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid/rdata stable, req_ready=0. A second req_valid during BUSY is not accepted until after the response handshake.
- Reset mid-op: assert rst_n=0 during BUSY of sw 0x12345678 @0x40 (previously 0) → outputs zero immediately; after release lw @0x40 = 0x00000000.
